// File: rtl/aha_tlx_pkg.sv
// Shared TLX training definitions: receive FSM state encodings, word geometry,
// and a saturating counter helper.
package aha_tlx_pkg;

  localparam int TLX_WORD_W = 32;
  localparam int TLX_IDX_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } tlx_rx_state_e;

  function automatic logic [TLX_WORD_W-1:0] sat_inc(input logic [TLX_WORD_W-1:0] v);
    return (&v) ? v : v + TLX_WORD_W'(1);
  endfunction

endpackage

// File: rtl/aha_tlx_input_capsule_pulse.sv
// Synchronous edge detector: one-cycle pulses on rising and falling edges of D.
module AhaSyncPulseGen (
  input  logic CLK,
  input  logic RESETn,
  input  logic D,
  output logic RISE_PULSE,
  output logic FALL_PULSE
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) d_q <= 1'b0;
    else         d_q <= D;
  end

  assign RISE_PULSE = D & ~d_q;
  assign FALL_PULSE = ~D & d_q;

endmodule

// File: rtl/aha_tlx_input_capsule.sv
// Receive-side TLX training capsule: aligns to a serial training word, checks
// following words bit-by-bit and counts good/bad words; passes data through otherwise.
module aha_tlx_input_capsule
  import aha_tlx_pkg::*;
#(
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_THRESH    = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  D_IN,
  input  logic                  START,
  input  logic                  CLEAR,
  input  logic [TLX_WORD_W-1:0] SEQUENCE,
  input  logic [TLX_WORD_W-1:0] LENGTH,
  input  logic                  AUTO_STOP,
  input  logic                  MODE,
  output logic                  D_OUT,
  output logic                  DONE,
  output logic                  ACTIVE,
  output logic                  LOCKED,
  output logic                  TIMEOUT,
  output logic [TLX_WORD_W-1:0] MATCH_COUNT,
  output logic [TLX_WORD_W-1:0] ERROR_COUNT
);

  logic start_pulse, clear_pulse, start_fall_unused, clear_fall_unused;

  AhaSyncPulseGen u_start_pulse (
    .CLK(CLK), .RESETn(RESETn), .D(START),
    .RISE_PULSE(start_pulse), .FALL_PULSE(start_fall_unused)
  );

  AhaSyncPulseGen u_clear_pulse (
    .CLK(CLK), .RESETn(RESETn), .D(CLEAR),
    .RISE_PULSE(clear_pulse), .FALL_PULSE(clear_fall_unused)
  );

  tlx_rx_state_e         state, state_next;
  logic [TLX_WORD_W-1:0] shreg, shreg_next, timer, timer_next;
  logic [TLX_WORD_W-1:0] match_cnt, match_next, err_cnt, err_next;
  logic [TLX_IDX_W-1:0]  idx, idx_next;
  logic [3:0]            consec_err, consec_next;
  logic                  word_err, word_err_next, relock, relock_next;
  logic                  done, done_next, timeout, timeout_next;
  logic [TLX_WORD_W-1:0] shifted;
  logic [TLX_WORD_W:0]   word_sum;
  logic                  bit_bad, word_bad;

  assign shifted = {D_IN, shreg[TLX_WORD_W-1:1]};
  assign bit_bad = D_IN != SEQUENCE[idx];

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    timer_next    = timer;
    match_next    = match_cnt;
    err_next      = err_cnt;
    idx_next      = idx;
    consec_next   = consec_err;
    word_err_next = word_err;
    relock_next   = relock;
    done_next     = done;
    timeout_next  = timeout;
    word_sum      = '0;
    word_bad      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_pulse) begin
          state_next   = ST_SEARCH;
          match_next   = '0;
          err_next     = '0;
          done_next    = 1'b0;
          timeout_next = 1'b0;
          shreg_next   = '0;
          timer_next   = '0;
          relock_next  = 1'b0;
        end
      end
      ST_SEARCH: begin
        shreg_next = shifted;
        if (shifted == SEQUENCE) begin
          match_next    = relock ? sat_inc(match_cnt) : TLX_WORD_W'(1);
          idx_next      = '0;
          consec_next   = '0;
          word_err_next = 1'b0;
          state_next    = (AUTO_STOP && LENGTH <= TLX_WORD_W'(1)) ? ST_FINISH : ST_CHECK;
        end else begin
          timer_next = timer + TLX_WORD_W'(1);
          if (AUTO_STOP && timer == TLX_WORD_W'(SEARCH_TIMEOUT - 1)) begin
            state_next   = ST_FINISH;
            timeout_next = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        idx_next = idx + TLX_IDX_W'(1);
        if (idx == TLX_IDX_W'(TLX_WORD_W - 1)) begin
          word_bad      = word_err | bit_bad;
          word_err_next = 1'b0;
          if (word_bad) begin
            err_next    = sat_inc(err_cnt);
            consec_next = (consec_err == 4'hF) ? consec_err : consec_err + 4'd1;
          end else begin
            match_next  = sat_inc(match_cnt);
            consec_next = '0;
          end
          // Length stop wins over loss of lock when both land on the same word.
          word_sum = {1'b0, match_next} + {1'b0, err_next};
          if (AUTO_STOP && word_sum >= {1'b0, LENGTH}) begin
            state_next = ST_FINISH;
          end else if (consec_next >= 4'(LOSS_THRESH)) begin
            state_next  = ST_SEARCH;
            shreg_next  = '0;
            timer_next  = '0;
            relock_next = 1'b1;
          end
        end else begin
          word_err_next = word_err | bit_bad;
        end
      end
      ST_FINISH: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (clear_pulse) begin
      state_next    = ST_IDLE;
      shreg_next    = '0;
      timer_next    = '0;
      match_next    = '0;
      err_next      = '0;
      idx_next      = '0;
      consec_next   = '0;
      word_err_next = 1'b0;
      relock_next   = 1'b0;
      done_next     = 1'b0;
      timeout_next  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      timer      <= '0;
      match_cnt  <= '0;
      err_cnt    <= '0;
      idx        <= '0;
      consec_err <= '0;
      word_err   <= 1'b0;
      relock     <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      timer      <= timer_next;
      match_cnt  <= match_next;
      err_cnt    <= err_next;
      idx        <= idx_next;
      consec_err <= consec_next;
      word_err   <= word_err_next;
      relock     <= relock_next;
      done       <= done_next;
      timeout    <= timeout_next;
    end
  end

  assign D_OUT       = MODE ? 1'b0 : D_IN;
  assign DONE        = done;
  assign TIMEOUT     = timeout;
  assign ACTIVE      = (state == ST_SEARCH) || (state == ST_CHECK);
  assign LOCKED      = (state == ST_CHECK);
  assign MATCH_COUNT = match_cnt;
  assign ERROR_COUNT = err_cnt;

endmodule

// File: doc/aha_tlx_input_capsule.md
Name: aha_tlx_input_capsule

Overview:
- Receive-side training capsule for one TLX PHY lane; counterpart of the TLX training output capsule.
- In training mode, searches the incoming serial bitstream for a 32-bit training word (sent LSB first), locks to word alignment, then checks each following word bit-by-bit and counts good and bad words.
- In normal mode, passes lane data through to the TLX. Sits between the PHY lane input and the TLX RX data input; controlled and observed through the training register block.

Parameters:
- SEARCH_TIMEOUT, 1024, SEARCH cycles without alignment before giving up (AUTO_STOP=1 only).
- LOSS_THRESH, 4, consecutive bad words in CHECK that drop lock (range 1..15).

Ports:
- CLK  input  1  clock
- RESETn  input  1  asynchronous, active-low reset
- D_IN  input  1  PHY lane serial data, sampled every CLK
- START  input  1  level; rising edge starts training receive
- CLEAR  input  1  level; rising edge aborts and clears status
- SEQUENCE  input  32  expected training word; bit 0 is received first
- LENGTH  input  32  total words to check (good + bad, including the aligning word)
- AUTO_STOP  input  1  1: stop after LENGTH words or on timeout; 0: run until CLEAR
- MODE  input  1  1: training receive; 0: pass-through
- D_OUT  output  1  data to TLX: D_IN when MODE=0, constant 0 when MODE=1
- DONE  output  1  sticky; training receive completed
- ACTIVE  output  1  state is SEARCH or CHECK
- LOCKED  output  1  state is CHECK
- TIMEOUT  output  1  sticky; search timed out
- MATCH_COUNT  output  32  good words, saturating
- ERROR_COUNT  output  32  bad words, saturating

Behaviour:
- Reset: state IDLE. DONE, TIMEOUT, MATCH_COUNT, ERROR_COUNT, shift register, idx and timer are all 0. ACTIVE=0, LOCKED=0.
- Edge detection: start_pulse and clear_pulse are one-cycle rising-edge pulses. The state changes on the CLK edge after the pulse.
- Clear priority: clear_pulse overrides everything in every state. It forces next state IDLE and zeroes DONE, TIMEOUT, both counters, shreg, idx and timer.
- START and CLEAR in the same cycle: CLEAR wins.
- State encoding: IDLE=0, SEARCH=1, CHECK=2, FINISH=3.
- IDLE:
  - start_pulse → SEARCH.
  - On entry to SEARCH, zero counters, DONE, TIMEOUT, shreg and timer.
- SEARCH:
  - Each cycle: shreg <= {D_IN, shreg[31:1]}.
  - Alignment hit when {D_IN, shreg[31:1]} == SEQUENCE.
  - On hit: MATCH_COUNT <= 1, idx <= 0, consec_err <= 0. If AUTO_STOP && LENGTH <= 1 → FINISH, else → CHECK.
  - No hit: timer increments. If AUTO_STOP && timer == SEARCH_TIMEOUT-1 → FINISH with TIMEOUT <= 1.
  - After re-entry to SEARCH from CHECK, an alignment hit increments MATCH_COUNT instead of loading 1.
- CHECK:
  - Each cycle compare D_IN with SEQUENCE[idx]; a mismatch sets the word_err flag. idx wraps 31→0.
  - Word complete at idx==31. bad = word_err | (D_IN != SEQUENCE[31]).
  - Good word: MATCH_COUNT++, consec_err <= 0.
  - Bad word: ERROR_COUNT++, consec_err++.
  - word_err is cleared at each word boundary.
  - Stop on length: if AUTO_STOP and post-increment (MATCH_COUNT+ERROR_COUNT) >= LENGTH → FINISH. This takes priority over loss of lock.
  - Loss of lock: else if consec_err reaches LOSS_THRESH → SEARCH, with shreg and timer zeroed and counters retained.
- FINISH: DONE <= 1; next state IDLE unconditionally.
- Counter width: both counters saturate at 32'hFFFFFFFF. The sum comparison is done in 33 bits.
- MODE: affects only D_OUT. The FSM runs regardless of MODE.
- START while not IDLE: ignored.
- AUTO_STOP changes mid-run: evaluated live each cycle.

Decomposition:
- Shared package (aha_tlx_pkg) holds:
  - state encodings;
  - TLX_WORD_W=32;
  - TLX_IDX_W=5.
- Sub-module: instantiate the codebase's synchronous rising/falling pulse generator AhaSyncPulseGen twice (START, CLEAR).
- Word checker stays inline.

Test Plan:
- Reset then idle: RESETn low, D_IN toggling → all outputs 0, D_OUT follows D_IN with MODE=0.
- Clean lock:
  - Stimulus: SEQUENCE=32'hA5C3_0F1E, LENGTH=4, AUTO_STOP=1, START; drive 7 random bits, then 4 words of the sequence LSB first.
  - Response: LOCKED rises on the cycle after the 32nd bit of word 1. MATCH_COUNT=4, ERROR_COUNT=0, DONE=1 and ACTIVE=0 two cycles after the last bit.
- Bit error:
  - Stimulus: same as clean lock with LENGTH=3; flip bit 17 of word 2.
  - Response: ERROR_COUNT=1, MATCH_COUNT=2, DONE=1, LOCKED never drops.
- Loss of lock:
  - Stimulus: LOSS_THRESH=4, AUTO_STOP=0; lock, then send 4 all-zero words.
  - Response: ERROR_COUNT=4, LOCKED=0, state SEARCH. Re-sending the sequence relocks with MATCH_COUNT=2.
- Timeout: SEARCH_TIMEOUT=1024, AUTO_STOP=1, D_IN=0 constant → TIMEOUT=1 and DONE=1 after 1024 SEARCH cycles, counters 0.
- Clear and start collision:
  - Stimulus: CLEAR mid-CHECK.
  - Response: next cycle IDLE, all status 0. START and CLEAR rising in the same cycle → stays IDLE.
